// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game sequencer.
// Cleans up the jump button (synchroniser + debouncer + edge detect), walks
// the TITLE/PLAYING/WON/LOST screens, holds the level block in reset outside
// PLAYING, and keeps saturating win/loss tallies.
module game_flow_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 25000000,
  parameter int GUARD_CYCLES    = 4
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       jump_button,
  input  logic       win,
  input  logic       lose,
  output logic       level_reset,
  output logic [1:0] screen,
  output logic [7:0] win_count,
  output logic [7:0] loss_count,
  output logic       press
);

  typedef enum logic [1:0] {
    TITLE   = 2'd0,
    PLAYING = 2'd1,
    WON     = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int T_MAX = (HOLDOFF_CYCLES > GUARD_CYCLES) ? HOLDOFF_CYCLES : GUARD_CYCLES;
  localparam int T_W   = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  logic            btn_p0;
  logic            btn_p1;
  logic            db_level_p2;
  logic            db_level_p3;
  logic [DB_W-1:0] db_cnt;
  logic [T_W-1:0]  timer;
  state_t          state;

  // Tallies stop at 255 rather than wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign screen = state;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= jump_button;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: accept a level change only after it has been stable long enough.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      db_level_p2 <= 1'b0;
      db_cnt      <= '0;
    end else if (btn_p1 == db_level_p2) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_p2 <= btn_p1;
      db_cnt      <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Stage p3: single-cycle pulse on each debounced rising edge.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      db_level_p3 <= 1'b0;
      press       <= 1'b0;
    end else begin
      db_level_p3 <= db_level_p2;
      press       <= db_level_p2 & ~db_level_p3;
    end
  end

  // Screen sequencer; one shared timer serves as guard in PLAYING and
  // holdoff on the result screens since those states never overlap.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state       <= TITLE;
      level_reset <= 1'b0;
      timer       <= '0;
      win_count   <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      if (timer != '0) timer <= timer - 1'b1;
      case (state)
        TITLE: begin
          if (press) begin
            state       <= PLAYING;
            level_reset <= 1'b1;
            timer       <= T_W'(GUARD_CYCLES);
          end
        end
        PLAYING: begin
          if (timer == '0) begin
            if (win) begin
              state       <= WON;
              level_reset <= 1'b0;
              win_count   <= sat_inc(win_count);
              timer       <= T_W'(HOLDOFF_CYCLES);
            end else if (lose) begin
              state       <= LOST;
              level_reset <= 1'b0;
              loss_count  <= sat_inc(loss_count);
              timer       <= T_W'(HOLDOFF_CYCLES);
            end
          end
        end
        WON, LOST: begin
          if (press && (timer == '0)) begin
            state       <= PLAYING;
            level_reset <= 1'b1;
            timer       <= T_W'(GUARD_CYCLES);
          end
        end
        default: begin
          state       <= TITLE;
          level_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller. Stimulus pushes each expected
// output event (press pulse or change of screen/level_reset/tallies) with the
// cycle it must appear in; a negedge monitor pops and compares every event.
module tb_game_flow_controller;

  logic       vga_clock;
  logic       reset;
  logic       jump_button;
  logic       win;
  logic       lose;
  logic       level_reset;
  logic [1:0] screen;
  logic [7:0] win_count;
  logic [7:0] loss_count;
  logic       press;

  game_flow_controller #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (10),
    .GUARD_CYCLES   (2)
  ) dut (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .jump_button(jump_button),
    .win        (win),
    .lose       (lose),
    .level_reset(level_reset),
    .screen     (screen),
    .win_count  (win_count),
    .loss_count (loss_count),
    .press      (press)
  );

  typedef struct {
    int         cyc;
    logic       pr;
    logic [1:0] scr;
    logic       lr;
    logic [7:0] wc;
    logic [7:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  always @(posedge vga_clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clock);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic p, input logic [1:0] s,
                           input logic l, input logic [7:0] w, input logic [7:0] lo);
    exp_t e;
    e.cyc = c; e.pr = p; e.scr = s; e.lr = l; e.wc = w; e.lc = lo;
    exp_q.push_back(e);
  endtask

  // Monitor: any press pulse or output change is an event to be checked.
  logic [18:0] prev_st;
  bit          first_s = 1'b1;
  always @(negedge vga_clock) begin
    logic [18:0] st;
    exp_t        e;
    st = {screen, level_reset, win_count, loss_count};
    if (first_s || press === 1'b1 || st !== prev_st) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d got press=%0b screen=%0d lr=%0b wc=%0d lc=%0d, required no event",
                 cyc, press, screen, level_reset, win_count, loss_count);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc >= 0 && e.cyc != cyc) || press !== e.pr || screen !== e.scr ||
            level_reset !== e.lr || win_count !== e.wc || loss_count !== e.lc) begin
          n_err++;
          $display("FAIL event got cyc=%0d press=%0b screen=%0d lr=%0b wc=%0d lc=%0d, required cyc=%0d press=%0b screen=%0d lr=%0b wc=%0d lc=%0d",
                   cyc, press, screen, level_reset, win_count, loss_count,
                   e.cyc, e.pr, e.scr, e.lr, e.wc, e.lc);
        end
      end
    end
    prev_st = st;
    first_s = 1'b0;
  end

  // One full round: press from screen s0, optionally win/lose from the first
  // PLAYING cycle, hold button 20 cycles, then release and let it settle.
  task automatic round(input logic w, input logic l,
                       input logic [1:0] s0, input logic [7:0] wc0, input logic [7:0] lc0,
                       input logic [1:0] s1, input logic [7:0] wc1, input logic [7:0] lc1);
    int c;
    c = cyc;
    jump_button = 1'b1;
    expect_ev(c + 7, 1'b1, s0, 1'b0, wc0, lc0);
    expect_ev(c + 8, 1'b0, 2'd1, 1'b1, wc0, lc0);
    tick(8);
    win  = w;
    lose = l;
    if (s1 != 2'd1) expect_ev(c + 11, 1'b0, s1, 1'b0, wc1, lc1);
    tick(12);
    jump_button = 1'b0;
    win  = 1'b0;
    lose = 1'b0;
    tick(8);
  endtask

  initial begin
    int         c;
    logic [7:0] wc;
    logic [7:0] nxt;
    exp_t       e;

    jump_button = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;
    reset       = 1'b1;
    expect_ev(-1, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
    #1 reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);

    // Bouncing button in TITLE: never stable for 4 cycles, so no event.
    for (int i = 0; i < 15; i++) begin
      jump_button = ~jump_button;
      tick(2);
    end
    jump_button = 1'b0;
    tick(10);

    // Clean press from TITLE, win from the first PLAYING cycle.
    round(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 2'd2, 8'd1, 8'd0);
    // Win and lose together: win takes priority.
    round(1'b1, 1'b1, 2'd2, 8'd1, 8'd0, 2'd2, 8'd2, 8'd0);

    // Lose, then a press inside the holdoff (discarded), then a late press.
    c = cyc;
    jump_button = 1'b1;
    expect_ev(c + 7, 1'b1, 2'd2, 1'b0, 8'd2, 8'd0);
    expect_ev(c + 8, 1'b0, 2'd1, 1'b1, 8'd2, 8'd0);
    tick(8);
    jump_button = 1'b0;
    tick(6);
    jump_button = 1'b1;
    tick(2);
    lose = 1'b1;
    expect_ev(c + 17, 1'b0, 2'd3, 1'b0, 8'd2, 8'd1);
    tick(2);
    lose = 1'b0;
    expect_ev(c + 21, 1'b1, 2'd3, 1'b0, 8'd2, 8'd1);
    tick(6);
    jump_button = 1'b0;
    tick(8);
    jump_button = 1'b1;
    expect_ev(c + 39, 1'b1, 2'd3, 1'b0, 8'd2, 8'd1);
    expect_ev(c + 40, 1'b0, 2'd1, 1'b1, 8'd2, 8'd1);
    tick(10);
    jump_button = 1'b0;
    tick(10);
    win = 1'b1;
    expect_ev(c + 53, 1'b0, 2'd2, 1'b0, 8'd3, 8'd1);
    tick(2);
    win = 1'b0;
    tick(12);

    // 256 more wins: tally must stick at 255.
    wc = 8'd3;
    for (int i = 0; i < 256; i++) begin
      nxt = (wc == 8'd255) ? 8'd255 : wc + 8'd1;
      round(1'b1, 1'b0, 2'd2, wc, 8'd1, 2'd2, nxt, 8'd1);
      wc = nxt;
    end

    // Enter PLAYING and stay there, then reset asynchronously mid-cycle.
    round(1'b0, 1'b0, 2'd2, 8'd255, 8'd1, 2'd1, 8'd255, 8'd1);
    #1;
    expect_ev(cyc, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_event got none, required cyc=%0d press=%0b screen=%0d lr=%0b wc=%0d lc=%0d",
               e.cyc, e.pr, e.scr, e.lr, e.wc, e.lc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level game sequencer placed directly downstream of the level block. Consumes the level's `win`/`lose` flags and the jump button. Drives the level's active-low reset, so each round starts from a freshly initialised level. Exposes the current screen (title / playing / won / lost) to the renderer and keeps saturating win/loss tallies.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (10 ms at 25 MHz)
- HOLDOFF_CYCLES, 25000000, minimum cycles spent on a result screen before a press is accepted
- GUARD_CYCLES, 4, cycles after entering PLAYING during which `win`/`lose` are ignored

Ports (clock and reset first):
- vga_clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; one clock, and this reset is asynchronous active-low
- jump_button  in  1  raw button, active-high when pressed, asynchronous to vga_clock
- win  in  1  level reports all coins collected
- lose  in  1  level reports goomba hit or time expired
- level_reset  out  1  active-low reset to the level block; low = level held in initial state
- screen  out  2  0 TITLE, 1 PLAYING, 2 WON, 3 LOST
- win_count  out  8  completed wins, saturating at 255
- loss_count  out  8  completed losses, saturating at 255
- press  out  1  one-cycle debounced press pulse, for debug LEDs

## Operation
- Button path:
  - two-flop synchroniser on jump_button, then a debouncer.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - `press` pulses for exactly one cycle on each debounced 0→1 edge. Holding the button gives one pulse only.
- FSM states: TITLE, PLAYING, WON, LOST; `screen` is the state encoding.
  - TITLE: on `press` → PLAYING.
  - PLAYING: guard counter loads GUARD_CYCLES on entry and counts down. While the counter is nonzero, win/lose are ignored. Afterwards, win=1 → WON with win_count+1; else lose=1 → LOST with loss_count+1. Win has priority when both are set in the same cycle.
  - WON / LOST: holdoff counter loads HOLDOFF_CYCLES on entry and counts down. A `press` while the counter is nonzero is discarded, with no queuing. A `press` with the counter at zero → PLAYING (replay directly, TITLE not revisited).
- level_reset = 1 only in PLAYING; 0 in every other state. It is registered, so it goes high in the same cycle `screen` becomes 1.
- Counters saturate: at 255 an increment leaves 255.
- Asynchronous reset asserted at any time: state TITLE, all counters cleared, level_reset 0, synchroniser and debouncer cleared to "released". This holds even mid-round or mid-debounce.

## Timing
- Reset values: screen=0, level_reset=0, win_count=0, loss_count=0, press=0.
- Button latency: synchroniser 2 cycles + DEBOUNCE_CYCLES + 1 register → `press` high. The FSM transition is visible on `screen`/`level_reset` in the cycle after `press` is high.
- Result latency: win/lose sampled high in cycle N (guard expired) → screen, count and level_reset updated at N+1.
- Guard window: win/lose are ignored in the first GUARD_CYCLES cycles with screen=1. The first cycle in which they are sampled is the (GUARD_CYCLES+1)th cycle of PLAYING.
- Holdoff: `press` is accepted only when HOLDOFF_CYCLES full cycles have elapsed since entering WON/LOST.
- A `press` coinciding with the win/lose transition cycle is discarded.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=10, GUARD_CYCLES=2.
- Reset, then a clean press held 20 cycles → one `press` pulse 7 cycles after the input edge. Next cycle: screen=1, level_reset=1. Only one pulse while held.
- In TITLE, button toggling every 2 cycles for 30 cycles → no `press`, screen stays 0.
- PLAYING, win=1 from the first PLAYING cycle → screen=2 exactly 3 cycles after entry, win_count=1, level_reset=0. With win and lose both high: WON, loss_count unchanged.
- In LOST, press accepted at holdoff cycle 5 → ignored, screen stays 3. Press after cycle 10 → screen=1, loss_count still 1.
- Force 256 wins → win_count stays 255. Assert reset mid-PLAYING → same-edge-independent: screen=0, counts=0, level_reset=0 immediately.
